// File: rtl/counter_monitor_pkg.sv
// Shared definitions for the counter monitor: FSM state encoding, default
// count width and the modular increment used to predict the next count.
package counter_pkg;

    localparam int DEF_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2,
        ALARM   = 2'd3
    } state_t;

    // Increment v modulo 2^w, for any w from 1 to 32.
    function automatic logic [31:0] cnt_next(input logic [31:0] v, input int unsigned w);
        logic [31:0] mask;
        mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return (v + 32'd1) & mask;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter with synchronous clear; SATURATE selects sticking at all-ones
// versus rolling over to zero.
module sat_counter #(
    parameter int W        = 16,
    parameter bit SATURATE = 1'b1
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && !(SATURATE && (count_q == '1))) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) count_q <= '0;
        else         count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/counter_monitor.sv
// Receive-side checker for a free-running counter: locks onto the count
// sequence, then counts bad samples and wraps and raises a sticky alarm.
module counter_monitor
    import counter_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int LOCK_CNT = 4,
    parameter int MAX_MISS = 3,
    parameter int ERR_W    = 16,
    parameter int WRAP_W   = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              mon_en,
    input  logic              clr,
    input  logic [WIDTH-1:0]  cnt,
    input  logic              cout,
    output logic              locked,
    output logic              alarm,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic [WIDTH-1:0]  bad_val
);

    localparam logic [3:0] LOCK_V = 4'(LOCK_CNT);
    localparam logic [3:0] MISS_V = 4'(MAX_MISS);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   prev_q;
    logic [3:0]         run_q, run_d;
    logic [3:0]         miss_q, miss_d;
    logic               first_q, first_d;
    logic               alarm_q, alarm_d;
    logic               captured_q, captured_d;
    logic [WIDTH-1:0]   bad_val_q, bad_val_d;
    logic [WIDTH-1:0]   exp_cnt;
    logic               good;
    logic               err_inc, wrap_inc, cnt_clr;

    assign exp_cnt = WIDTH'(cnt_next(32'(prev_q), WIDTH));
    assign good    = (cnt == exp_cnt) && (cout == (cnt == '1));

    always_comb begin
        state_d    = state_q;
        run_d      = run_q;
        miss_d     = miss_q;
        first_d    = first_q;
        alarm_d    = alarm_q;
        captured_d = captured_q;
        bad_val_d  = bad_val_q;
        err_inc    = 1'b0;
        wrap_inc   = 1'b0;
        cnt_clr    = 1'b0;

        if (!mon_en) begin
            state_d = IDLE;
            run_d   = '0;
            miss_d  = '0;
        end else if (clr) begin
            state_d    = ACQUIRE;
            run_d      = '0;
            miss_d     = '0;
            first_d    = 1'b1;
            alarm_d    = 1'b0;
            captured_d = 1'b0;
            bad_val_d  = '0;
            cnt_clr    = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ACQUIRE;
                    run_d   = '0;
                    first_d = 1'b1;
                end
                ACQUIRE: begin
                    // The entry sample only seeds prev_q; judging starts one edge later.
                    if (first_q) begin
                        first_d = 1'b0;
                    end else if (good) begin
                        run_d = run_q + 4'd1;
                        if (run_d == LOCK_V) begin
                            state_d = LOCKED;
                            miss_d  = '0;
                        end
                    end else begin
                        run_d = '0;
                    end
                end
                LOCKED: begin
                    if (good) begin
                        miss_d   = '0;
                        wrap_inc = (cnt == '0);
                    end else begin
                        err_inc = 1'b1;
                        miss_d  = miss_q + 4'd1;
                        if (!captured_q) begin
                            captured_d = 1'b1;
                            bad_val_d  = cnt;
                        end
                        if (miss_d == MISS_V) begin
                            alarm_d = 1'b1;
                            state_d = ALARM;
                        end
                    end
                end
                ALARM: begin
                    err_inc = !good;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            prev_q     <= '0;
            run_q      <= '0;
            miss_q     <= '0;
            first_q    <= 1'b0;
            alarm_q    <= 1'b0;
            captured_q <= 1'b0;
            bad_val_q  <= '0;
        end else begin
            state_q    <= state_d;
            prev_q     <= cnt;
            run_q      <= run_d;
            miss_q     <= miss_d;
            first_q    <= first_d;
            alarm_q    <= alarm_d;
            captured_q <= captured_d;
            bad_val_q  <= bad_val_d;
        end
    end

    sat_counter #(.W(ERR_W), .SATURATE(1'b1)) u_err (
        .clk     (clk),
        .resetn  (resetn),
        .clr_i   (cnt_clr),
        .inc_i   (err_inc),
        .count_o (err_cnt)
    );

    sat_counter #(.W(WRAP_W), .SATURATE(1'b0)) u_wrap (
        .clk     (clk),
        .resetn  (resetn),
        .clr_i   (cnt_clr),
        .inc_i   (wrap_inc),
        .count_o (wrap_cnt)
    );

    assign locked  = (state_q == LOCKED);
    assign alarm   = alarm_q;
    assign bad_val = bad_val_q;

endmodule

// File: tb/tb_counter_monitor.sv
// Directed bench for counter_monitor; a second instance with narrow counters
// shares the stimulus to exercise saturation and roll-over.
module tb_counter_monitor;

    logic        clk;
    logic        resetn;
    logic        mon_en;
    logic        clr;
    logic [3:0]  cnt;
    logic        cout;

    logic        locked,   locked_s;
    logic        alarm,    alarm_s;
    logic [15:0] err_cnt;
    logic [3:0]  err_cnt_s;
    logic [15:0] wrap_cnt;
    logic [1:0]  wrap_cnt_s;
    logic [3:0]  bad_val,  bad_val_s;

    int npass  = 0;
    int ntotal = 0;
    logic [3:0] c;

    counter_monitor dut (
        .clk      (clk),
        .resetn   (resetn),
        .mon_en   (mon_en),
        .clr      (clr),
        .cnt      (cnt),
        .cout     (cout),
        .locked   (locked),
        .alarm    (alarm),
        .err_cnt  (err_cnt),
        .wrap_cnt (wrap_cnt),
        .bad_val  (bad_val)
    );

    counter_monitor #(.ERR_W(4), .WRAP_W(2)) dut_s (
        .clk      (clk),
        .resetn   (resetn),
        .mon_en   (mon_en),
        .clr      (clr),
        .cnt      (cnt),
        .cout     (cout),
        .locked   (locked_s),
        .alarm    (alarm_s),
        .err_cnt  (err_cnt_s),
        .wrap_cnt (wrap_cnt_s),
        .bad_val  (bad_val_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick(input logic [3:0] v, input logic co);
        cnt  = v;
        cout = co;
        @(posedge clk);
        #1;
    endtask

    task automatic good(input int n);
        for (int i = 0; i < n; i++) begin
            tick(c, c == 4'd15);
            c = c + 4'd1;
        end
    endtask

    initial begin
        resetn = 1'b0;
        mon_en = 1'b0;
        clr    = 1'b0;
        cnt    = '0;
        cout   = 1'b0;
        c      = '0;
        #3;
        chk("rst_locked", locked, 0);
        chk("rst_alarm", alarm, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_wrap", wrap_cnt, 0);
        chk("rst_badval", bad_val, 0);

        // Clean counter from 0: entry, one seed edge, then four good samples.
        @(negedge clk);
        resetn = 1'b1;
        mon_en = 1'b1;
        good(5);
        chk("lock_early", locked, 0);
        good(1);
        chk("lock_rise", locked, 1);
        good(48);
        chk("run_wrap3", wrap_cnt, 3);
        chk("run_err0", err_cnt, 0);
        chk("run_alarm0", alarm, 0);
        chk("run_wrap3_narrow", wrap_cnt_s, 3);

        // Skip 6 -> 8.
        good(1);
        tick(4'd8, 1'b0);
        c = 4'd9;
        good(1);
        chk("skip_err", err_cnt, 1);
        chk("skip_badval", bad_val, 8);
        chk("skip_locked", locked, 1);
        chk("skip_alarm", alarm, 0);

        // Fourth wrap: narrow wrap counter rolls 3 -> 0.
        good(7);
        chk("wrap4", wrap_cnt, 4);
        chk("wrap_roll_narrow", wrap_cnt_s, 0);

        // 15 with missing carry is bad; the following 0 is good.
        good(14);
        tick(4'd15, 1'b0);
        c = 4'd0;
        chk("nocout_err", err_cnt, 2);
        good(1);
        chk("zero_after15_err", err_cnt, 2);
        chk("badval_kept", bad_val, 8);
        good(2);
        tick(4'd3, 1'b1);
        c = 4'd4;
        chk("spurious_cout_err", err_cnt, 3);
        good(1);

        // Counter stuck at 0: alarm on the third bad edge.
        tick(4'd0, 1'b0);
        tick(4'd0, 1'b0);
        chk("stuck2_alarm", alarm, 0);
        chk("stuck2_locked", locked, 1);
        chk("stuck2_err", err_cnt, 5);
        tick(4'd0, 1'b0);
        chk("stuck3_alarm", alarm, 1);
        chk("stuck3_locked", locked, 0);
        chk("stuck3_err", err_cnt, 6);

        clr = 1'b1;
        tick(4'd0, 1'b0);
        clr = 1'b0;
        chk("clr_err", err_cnt, 0);
        chk("clr_alarm", alarm, 0);
        chk("clr_badval", bad_val, 0);
        chk("clr_wrap", wrap_cnt, 0);
        chk("clr_locked", locked, 0);
        c = 4'd1;
        good(4);
        chk("relock_early", locked, 0);
        good(1);
        chk("relock", locked, 1);
        chk("relock_err", err_cnt, 0);

        // Alarm again, then keep feeding bad samples to saturate narrow err_cnt.
        for (int i = 0; i < 23; i++) tick(4'd0, 1'b0);
        chk("sat_alarm", alarm, 1);
        chk("sat_err_wide", err_cnt, 23);
        chk("sat_err_narrow", err_cnt_s, 15);

        // Disable while in ALARM: counters and alarm hold.
        mon_en = 1'b0;
        tick(4'd0, 1'b0);
        chk("dis_locked", locked, 0);
        chk("dis_alarm_hold", alarm, 1);
        chk("dis_err_hold", err_cnt, 23);

        mon_en = 1'b1;
        clr    = 1'b1;
        tick(4'd0, 1'b0);
        clr    = 1'b0;
        chk("clr2_alarm", alarm, 0);
        chk("clr2_err", err_cnt, 0);

        // Drop enable mid-ACQUIRE; the partial run must not survive.
        c = 4'd1;
        good(3);
        mon_en = 1'b0;
        good(1);
        chk("acq_drop_locked", locked, 0);
        mon_en = 1'b1;
        good(1);
        good(4);
        chk("acq_run_cleared", locked, 0);
        good(1);
        chk("acq_relock", locked, 1);

        // Repeated wrong value 2 while expecting 11: three misses.
        tick(4'd2, 1'b0);
        tick(4'd2, 1'b0);
        tick(4'd2, 1'b0);
        chk("alarm3_alarm", alarm, 1);
        chk("alarm3_badval", bad_val, 2);
        chk("alarm3_err", err_cnt, 3);

        // Asynchronous reset between clock edges.
        #2;
        resetn = 1'b0;
        #1;
        chk("async_locked", locked, 0);
        chk("async_alarm", alarm, 0);
        chk("async_err", err_cnt, 0);
        chk("async_wrap", wrap_cnt, 0);
        chk("async_badval", bad_val, 0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
